// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters/UART and the TX arbiter.
// The slave modport is the arbiter; master is the requester and UART side.
interface uart_tx_arbiter_if #(
  parameter int unsigned kNumPorts = 4
) ();
  localparam int unsigned kIdW = $clog2(kNumPorts);

  logic [8*kNumPorts-1:0] req_data;
  logic [kNumPorts-1:0]   req_valid;
  logic [kNumPorts-1:0]   req_last;
  logic [kNumPorts-1:0]   req_ready;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [kIdW-1:0]        grant_id;
  logic                   busy;

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX channel among byte-stream requesters.
// A grant is held for a whole packet or kMaxBurst bytes, whichever ends first.
module uart_tx_arbiter #(
  parameter int unsigned kNumPorts = 4,
  parameter int unsigned kMaxBurst = 64
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus_io
);
  localparam int unsigned kIdW = $clog2(kNumPorts);

  typedef enum logic {StIdle, StSend} state_e;

  state_e          state_q;
  logic [kIdW-1:0] grant_id_q;
  logic [kIdW-1:0] last_grant_q;
  logic [7:0]      byte_cnt_q;

  logic [kIdW-1:0] sel;
  logic            xfer;
  logic            rel_now;

  function automatic logic [kIdW-1:0] wrap_idx(input int unsigned v);
    return kIdW'(v % kNumPorts);
  endfunction

  // Scan downward so the nearest valid port after last_grant wins.
  always_comb begin
    sel = '0;
    for (int unsigned off = kNumPorts; off != 0; off--) begin
      if (bus_io.req_valid[wrap_idx(32'(last_grant_q) + off)]) begin
        sel = wrap_idx(32'(last_grant_q) + off);
      end
    end
  end

  always_comb begin
    bus_io.tx_data   = '0;
    bus_io.tx_valid  = 1'b0;
    bus_io.req_ready = '0;
    if (state_q == StSend) begin
      bus_io.tx_data               = bus_io.req_data[{grant_id_q, 3'b000} +: 8];
      bus_io.tx_valid              = bus_io.req_valid[grant_id_q];
      bus_io.req_ready[grant_id_q] = bus_io.tx_ready;
    end
  end

  assign xfer    = bus_io.tx_valid && bus_io.tx_ready;
  assign rel_now = xfer && (bus_io.req_last[grant_id_q] || (byte_cnt_q == 8'(kMaxBurst - 1)));

  assign bus_io.busy     = (state_q == StSend);
  assign bus_io.grant_id = grant_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_id_q   <= '0;
      last_grant_q <= kIdW'(kNumPorts - 1);
      byte_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus_io.req_valid) begin
            grant_id_q <= sel;
            byte_cnt_q <= '0;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 8'd1;
            // Forced release leaves req_last pending; the port re-arbitrates.
            if (rel_now) begin
              state_q      <= StIdle;
              last_grant_q <= grant_id_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit channel between several byte-stream requesters (command responder, debug logger, status reporter, …). Each requester presents bytes on a valid/ready interface with a `last` marker. The arbiter locks the channel to one requester for a whole packet, or for up to `kMaxBurst` bytes, then rotates. It sits directly in front of the `uart` block's `tx_data`/`tx_valid`/`tx_ready` port.

## Interface

Parameters:
- `kNumPorts`, default 4: number of requesters, 2..8.
- `kMaxBurst`, default 64: maximum bytes per grant before forced release, 1..255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_data`  in  8*kNumPorts  byte from requester i on bits [8i+7:8i].
- `req_valid`  in  kNumPorts  requester i has a byte.
- `req_last`  in  kNumPorts  byte from requester i ends its packet.
- `req_ready`  out  kNumPorts  byte from requester i accepted this cycle (valid & ready).
- `tx_data`  out  8  byte to UART.
- `tx_valid`  out  1  byte to UART valid.
- `tx_ready`  in  1  UART accepts byte.
- `grant_id`  out  $clog2(kNumPorts)  index of the currently granted requester.
- `busy`  out  1  a grant is held (state SEND).

## Operation

- FSM has two states, IDLE and SEND. Registers:
  - `state`
  - `grant_id`
  - `last_grant` (same width as `grant_id`)
  - `byte_cnt` (8 bits)
- IDLE:
  - If any `req_valid` bit is set, select the first set bit scanning upward from `last_grant+1`, wrapping modulo `kNumPorts`.
  - Register the selection into `grant_id`, clear `byte_cnt`, go to SEND.
  - If no `req_valid` bit is set, stay in IDLE.
- SEND, datapath is combinational from `grant_id`:
  - `tx_data = req_data[grant_id]`
  - `tx_valid = req_valid[grant_id]`
  - `req_ready[grant_id] = tx_ready`
  - All other `req_ready` bits are 0.
- Transfer occurs when `tx_valid && tx_ready`. On a transfer, `byte_cnt` increments.
- Release: on a transfer where `req_last[grant_id]` is set or `byte_cnt == kMaxBurst-1`:
  - Go to IDLE.
  - `last_grant <= grant_id`.
  - `grant_id` holds its value.
- The grant is held while the granted requester deasserts `req_valid` mid-packet. `tx_valid` drops to 0, no timeout applies, and other requesters wait.
- In IDLE: `tx_valid = 0`, all `req_ready = 0`, `busy = 0`.
- `req_last` is ignored on non-granted ports and on cycles without a transfer.
- Reset values:
  - `state` = IDLE.
  - `grant_id` = 0.
  - `last_grant` = kNumPorts-1, so port 0 wins the first arbitration.
  - `byte_cnt` = 0.
  - Outputs: `tx_valid = 0`, `req_ready = 0`, `busy = 0`.

## Timing

- Arbitration latency is 1 cycle. If a request is seen in IDLE at edge t, `busy`, `grant_id` and `tx_valid` are valid after edge t.
- `tx_data`, `tx_valid` and `req_ready` have no registered stage in SEND. A byte presented with `tx_ready` high transfers in the same cycle.
- Between packets there is exactly one IDLE cycle: release edge, then arbitration edge.
- A requester asserting valid in the same cycle as another port's release is considered at the following IDLE cycle. No request is lost.
- Forced release at `kMaxBurst` bytes does not consume `req_last`. The remainder of the packet re-arbitrates normally and may be interleaved with other ports.
- `kMaxBurst = 1` degenerates to byte-level round-robin.
- Reset asserted mid-packet:
  - Returns to IDLE on the next edge.
  - A transfer in the reset cycle is not counted.
  - Requesters must tolerate packet truncation.
- `req_valid`/`req_data`/`req_last` from the granted port must be stable while valid and not ready. The arbiter relies on this and does not check it.

## Test plan

- Reset, then all ports idle for 10 cycles: `tx_valid = 0`, `busy = 0`, `grant_id = 0`, `req_ready = 0` every cycle.
- Port 2 sends bytes 0xA7, 0x3C with last on 0x3C, `tx_ready` tied 1. Expected:
  - `grant_id = 2`, 1 cycle after valid.
  - Two transfers on consecutive cycles, `req_ready[2]` high for both.
  - Then IDLE, with `last_grant = 2`.
- Ports 0, 1 and 3 each hold a 1-byte packet continuously. Grants proceed in order 0, 1, 3, 0, … with exactly one IDLE cycle between packets.
- `kMaxBurst = 4`, port 1 sends 6 bytes 0x10..0x15 while port 0 also requests. Expected:
  - 0x10..0x13 go out from port 1.
  - Then port 0's packet.
  - Then 0x14, 0x15 from port 1.
- Granted port drops valid for 5 cycles mid-packet while port 3 requests. Expected:
  - `tx_valid = 0` and `grant_id` unchanged for those 5 cycles.
  - Port 3 is served only after the granted packet's last byte.
- `tx_ready` held 0 for 20 cycles then released. Expected:
  - `tx_data` stable at the first byte and `req_ready` stays 0 throughout.
  - A single transfer when `tx_ready` rises.
  - Reset asserted mid-packet on a later run returns all outputs to reset values at the next edge.
